// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div_op(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Radix-2 shift-add multiplier / restoring divider for the EX stage; one shared
// 2*XLEN accumulator, stalls the front of the pipe while it iterates.
//
// state | meaning
// IDLE  | waiting for start; special divides resolved here
// CALC  | XLEN shift-add or shift-subtract iterations
// FIX   | apply sign, select result half
// DONE  | result valid for one cycle
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     mag_b_q, mag_b_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e        op_in;
  logic              sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_by_zero, div_ovf;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   rem_fix;

  assign op_in = muldiv_op_e'(op);
  assign sa    = is_signed_a(op_in) & a[XLEN-1];
  assign sb    = is_signed_b(op_in) & b[XLEN-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  assign div_by_zero = is_div_op(op_in) && (b == '0);
  assign div_ovf     = (op_in == OP_DIV || op_in == OP_REM) && (a == MIN_NEG) && (b == '1);

  // Multiply: add multiplicand into the high half when the multiplier LSB is set.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? mag_b_q : '0);
  // Divide: {rem,quo} shifted left by one; trial difference sign decides restore.
  assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign diff    = rem_sh - mag_b_q;

  // Low half of the negated 2*XLEN word is also the negated quotient.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mag_b_q  <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mag_b_q  <= mag_b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mag_b_d  = mag_b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d    = op_in;
          rd_d    = rd_in;
          mag_b_d = {1'b0, abs_b};
          acc_d   = {{XLEN{1'b0}}, abs_a};
          count_d = CNT_W'(XLEN - 1);
          neg_d   = is_rem_op(op_in) ? sa : (sa ^ sb);
          state_d = CALC;
          if (div_by_zero) begin
            result_d = is_rem_op(op_in) ? a : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = is_rem_op(op_in) ? '0 : MIN_NEG;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        if (is_div_op(op_q)) begin
          acc_d = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        count_d = count_q - 1'b1;
        if (count_q == '0) state_d = FIX;
      end
      FIX: begin
        unique case (op_q)
          OP_MUL, OP_DIV, OP_DIVU:       result_d = prod_fix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*XLEN-1:XLEN];
          default:                       result_d = rem_fix;
        endcase
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (kill && state_q != IDLE) state_d = IDLE;
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = (state_q == IDLE && start && !kill) || (state_q == CALC) || (state_q == FIX);
  assign done      = (state_q == DONE) && !kill;
  assign result    = done ? result_q : '0;
  assign rd_out    = rd_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver pushes expected results, a negedge
// monitor pops and compares them whenever done is presented.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, kill;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .kill(kill), .busy(busy), .stall_req(stall_req),
    .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      ux = longint'({32'b0, x});
    longint      uy = longint'({32'b0, y});
    int          ix = x;
    int          iy = y;
    logic [63:0] p;
    case (f3)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ix / iy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return ix % iy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Monitor: any done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
          chk("done_cycle", cyc, e.cyc);
        end
      end else begin
        chk("result_zero_when_idle", result, 32'd0);
      end
    end
  end

  // Issue one op at a negedge with the FSM idle. abort_at>0 aborts at that
  // relative cycle via kill (use_reset=0) or reset (use_reset=1).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input int abort_at, input bit use_reset);
    bit special;
    int lat;
    logic [4:0] rd;
    special = f3[2] && (y == 0 || (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    lat = special ? 1 : 34;
    rd  = 5'($urandom_range(1, 31));
    start = 1'b1; op = f3; a = x; b = y; rd_in = rd;
    #1;
    chk("stall_at_issue", {31'b0, stall_req}, 32'd1);
    chk("busy_at_issue", {31'b0, busy}, 32'd0);
    if (abort_at == 0) sb_q.push_back('{res: exp_res, rd: rd, cyc: cyc + lat});
    for (int rel = 1; rel <= lat; rel++) begin
      @(negedge clk);
      chk("stall_window", {31'b0, stall_req}, {31'b0, rel < lat});
      chk("busy_window", {31'b0, busy}, 32'd1);
      if (abort_at != 0 && rel == abort_at) begin
        if (use_reset) begin
          reset = 1'b1; start = 1'b0;
          #1;
          chk("rst_busy", {31'b0, busy}, 32'd0);
          chk("rst_stall", {31'b0, stall_req}, 32'd0);
          chk("rst_done", {31'b0, done}, 32'd0);
          chk("rst_result", result, 32'd0);
          chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
          @(negedge clk);
          reset = 1'b0;
        end else begin
          kill = 1'b1;
          @(negedge clk);
          kill = 1'b0; start = 1'b0;
          chk("kill_busy", {31'b0, busy}, 32'd0);
          chk("kill_stall", {31'b0, stall_req}, 32'd0);
        end
        repeat (2) @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stall", {31'b0, stall_req}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", {27'b0, rd_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0, 0);
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    do_op(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0, 0);
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 0);
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0, 0);
    do_op(3'd5, 32'd100,        32'd7,         32'd14,        0, 0);
    do_op(3'd7, 32'd100,        32'd7,         32'd2,         0, 0);
    do_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0, 0);
    do_op(3'd6, 32'd5,          32'd0,         32'd5,         0, 0);
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0, 0);

    do_op(3'd5, 32'd1000, 32'd3, 32'd0, 10, 0);
    do_op(3'd5, 32'd1000, 32'd3, 32'd333, 0, 0);

    do_op(3'd0, 32'd12345, 32'd678, 32'd0, 15, 1);
    do_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      do_op(rop, ra, rb, ref_model(rop, ra, rb), 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
